wb_write_arbiter: RTL

- Write-back arbiter that drives the single synchronous write port of the MIPS 3-port register file (WE / w_AD / w_D).
- Merges two write sources:
  - the in-order pipeline write-back, which has priority and no back-pressure;
  - a long-latency unit (multiply/divide, load miss) over a valid/ready handshake, buffered in a small FIFO.
- Provides a pending-write query for the hazard unit and a stall request when the queued source is starved.

---
 rtl/wb_write_arbiter_pkg.sv | 16 +
 rtl/wb_write_arbiter_if.sv | 34 +++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_write_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter: queued entry layout and
// the register-file geometry it is built around.
package wb_write_arbiter_pkg;

  localparam int unsigned AD_BIT   = 3;
  localparam int unsigned DATA_BIT = 8;

  localparam logic [AD_BIT-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                live;
    logic [AD_BIT-1:0]   ad;
    logic [DATA_BIT-1:0] d;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of pipeline, long-latency, hazard-query and register-file signals
// around the write-back arbiter.
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned AD_bit   = AD_BIT,
  parameter int unsigned Data_bit = DATA_BIT
);

  logic                p_we;
  logic [AD_bit-1:0]   p_AD;
  logic [Data_bit-1:0] p_D;
  logic                m_valid;
  logic                m_ready;
  logic [AD_bit-1:0]   m_AD;
  logic [Data_bit-1:0] m_D;
  logic [AD_bit-1:0]   q_AD;
  logic                q_pending;
  logic                stall_req;
  logic                WE;
  logic [AD_bit-1:0]   w_AD;
  logic [Data_bit-1:0] w_D;

  modport slave (
    input  p_we, p_AD, p_D, m_valid, m_AD, m_D, q_AD,
    output m_ready, q_pending, stall_req, WE, w_AD, w_D
  );

  modport master (
    output p_we, p_AD, p_D, m_valid, m_AD, m_D, q_AD,
    input  m_ready, q_pending, stall_req, WE, w_AD, w_D
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of queued long-latency writes with kill-by-address (live bits
// cleared in place) and a live-entry address match for hazard queries.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  wb_entry_t         i_push_entry,
  input  logic              i_pop,
  output wb_entry_t         o_head,
  output logic [CntW-1:0]   o_count,
  input  logic              i_kill,
  input  logic [AD_BIT-1:0] i_kill_ad,
  input  logic [AD_BIT-1:0] i_match_ad,
  output logic              o_match
);

  wb_entry_t       r_mem [Depth];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (i_kill && (r_mem[i].ad == i_kill_ad)) r_mem[i].live <= 1'b0;
      end
      // Popped slots are marked dead so live alone implies occupancy.
      if (i_pop) begin
        r_mem[r_head].live <= 1'b0;
        r_head             <= r_head + PtrW'(1);
      end
      if (i_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= r_tail + PtrW'(1);
      end
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  always_comb begin
    o_match = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (r_mem[i].live && (r_mem[i].ad == i_match_ad)) o_match = 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, long-latency
// results drain from a small queue, with starvation-driven stall request.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned Q_DEPTH    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               CLK,
  input logic               RST_n,
  wb_write_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(Q_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  logic                w_p_wr;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_match;
  logic [CntW-1:0]     w_count;
  wb_entry_t           w_head;
  wb_entry_t           w_push_entry;
  logic [StW-1:0]      r_starve;
  logic [StW-1:0]      w_starve_d;
  logic                r_stall;
  logic                r_we;
  logic [AD_BIT-1:0]   r_ad;
  logic [DATA_BIT-1:0] r_d;
  logic                w_we_d;
  logic [AD_BIT-1:0]   w_ad_d;
  logic [DATA_BIT-1:0] w_d_d;

  assign w_p_wr      = bus.p_we && (bus.p_AD != REG_ZERO);
  assign bus.m_ready = RST_n && (w_count < CntW'(Q_DEPTH));
  assign w_accept    = bus.m_valid && bus.m_ready;
  // A same-cycle long-latency result to the pipeline's target is already stale.
  assign w_push      = w_accept && (bus.m_AD != REG_ZERO) && !(w_p_wr && (bus.m_AD == bus.p_AD));
  assign w_pop       = !w_p_wr && (w_count != '0);
  assign w_push_entry = '{live: 1'b1, ad: bus.m_AD, d: bus.m_D};
  assign bus.q_pending = w_match && (bus.q_AD != REG_ZERO);

  wb_fifo #(
    .Depth (Q_DEPTH)
  ) u_fifo (
    .i_clk        (CLK),
    .i_rst_n      (RST_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .i_kill       (w_p_wr),
    .i_kill_ad    (bus.p_AD),
    .i_match_ad   (bus.q_AD),
    .o_match      (w_match)
  );

  always_comb begin
    w_we_d = 1'b0;
    w_ad_d = r_ad;
    w_d_d  = r_d;
    if (w_p_wr) begin
      w_we_d = 1'b1;
      w_ad_d = bus.p_AD;
      w_d_d  = bus.p_D;
    end else if (w_pop) begin
      w_we_d = w_head.live;
      w_ad_d = w_head.ad;
      w_d_d  = w_head.d;
    end
  end

  // With a non-empty queue, every cycle is either a pop or a blocked cycle.
  always_comb begin
    w_starve_d = r_starve;
    if (w_pop || (w_count == '0)) begin
      w_starve_d = '0;
    end else if (r_starve != StW'(STARVE_MAX)) begin
      w_starve_d = r_starve + StW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_we     <= 1'b0;
      r_ad     <= '0;
      r_d      <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_we     <= w_we_d;
      r_ad     <= w_ad_d;
      r_d      <= w_d_d;
      r_starve <= w_starve_d;
      r_stall  <= (w_starve_d == StW'(STARVE_MAX));
    end
  end

  assign bus.WE        = r_we;
  assign bus.w_AD      = r_ad;
  assign bus.w_D       = r_d;
  assign bus.stall_req = r_stall;

endmodule
